// File: rtl/uart_prog_loader.sv
// ---------------------------------------------------------------------------
// uart_prog_loader
//
// Boot sequencer that sits between a UART receiver and the instruction
// memory. Received bytes are packed little-endian into 32-bit words and
// written to consecutive word addresses starting at 0. The CPU core is held
// in reset until WORD_COUNT words are written. It is then released and
// load_done is raised. A reload request restarts the load at any time.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   rx_data     received byte, qualified by rx_valid
//   rx_valid    one-cycle strobe, one byte per strobe
//   reload      one-cycle request to restart loading from address 0
//   imem_we     instruction-memory write enable, one pulse per word
//   imem_addr   word address of the write (held between pulses)
//   imem_wdata  assembled word (held between pulses)
//   cpu_rst     reset to the CPU core, high while loading
//   load_done   high while the CPU runs a fully loaded image
//   timeout_err sticky flag: a partial word was discarded on timeout
// ---------------------------------------------------------------------------
module uart_prog_loader #(
  parameter int WORD_COUNT     = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst,
  output logic                  load_done,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  // The word index is one bit wider than the address so that it can hold
  // WORD_COUNT itself when WORD_COUNT == 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(WORD_COUNT - 1);
  localparam logic [ADDR_WIDTH:0] IDX_ONE  = (ADDR_WIDTH + 1)'(1);

  // The timeout fires on the idle cycle that would bring the gap count to
  // TIMEOUT_CYCLES, so the counter itself never needs to hold that value.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH:0]   word_idx_reg, word_idx_next;
  logic [1:0]            byte_cnt_reg, byte_cnt_next;
  logic [GAP_W-1:0]      gap_reg, gap_next;
  logic [31:0]           word_buf_reg, word_buf_next;

  logic                  imem_we_reg, imem_we_next;
  logic [ADDR_WIDTH-1:0] imem_addr_reg, imem_addr_next;
  logic [31:0]           imem_wdata_reg, imem_wdata_next;
  logic                  cpu_rst_reg, cpu_rst_next;
  logic                  load_done_reg, load_done_next;
  logic                  timeout_err_reg, timeout_err_next;

  // Word buffer with the incoming byte merged into the lane selected by
  // byte_cnt. When byte_cnt is 3 this is the complete word to be written.
  logic [31:0]           assembled;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign assembled[gi*8 +: 8] = (byte_cnt_reg == 2'(gi)) ? rx_data
                                                              : word_buf_reg[gi*8 +: 8];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= LOAD;
      word_idx_reg    <= '0;
      byte_cnt_reg    <= '0;
      gap_reg         <= '0;
      word_buf_reg    <= '0;
      imem_we_reg     <= 1'b0;
      imem_addr_reg   <= '0;
      imem_wdata_reg  <= '0;
      cpu_rst_reg     <= 1'b1;
      load_done_reg   <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      word_idx_reg    <= word_idx_next;
      byte_cnt_reg    <= byte_cnt_next;
      gap_reg         <= gap_next;
      word_buf_reg    <= word_buf_next;
      imem_we_reg     <= imem_we_next;
      imem_addr_reg   <= imem_addr_next;
      imem_wdata_reg  <= imem_wdata_next;
      cpu_rst_reg     <= cpu_rst_next;
      load_done_reg   <= load_done_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    word_idx_next    = word_idx_reg;
    byte_cnt_next    = byte_cnt_reg;
    gap_next         = gap_reg;
    word_buf_next    = word_buf_reg;
    imem_we_next     = 1'b0;
    imem_addr_next   = imem_addr_reg;
    imem_wdata_next  = imem_wdata_reg;
    cpu_rst_next     = cpu_rst_reg;
    load_done_next   = load_done_reg;
    timeout_err_next = timeout_err_reg;

    if (reload) begin
      // Reload beats any byte arriving in the same cycle. A 4th byte here is
      // dropped, so no write pulse follows. A pulse already on the output
      // this cycle is left alone because the write register is not touched.
      state_next       = LOAD;
      word_idx_next    = '0;
      byte_cnt_next    = '0;
      gap_next         = '0;
      cpu_rst_next     = 1'b1;
      load_done_next   = 1'b0;
      timeout_err_next = 1'b0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (rx_valid) begin
            gap_next      = '0;
            word_buf_next = assembled;
            if (byte_cnt_reg == 2'd3) begin
              imem_we_next    = 1'b1;
              imem_addr_next  = word_idx_reg[ADDR_WIDTH-1:0];
              imem_wdata_next = assembled;
              byte_cnt_next   = '0;
              word_idx_next   = word_idx_reg + IDX_ONE;
              if (word_idx_reg == LAST_IDX) begin
                state_next = DRAIN;
              end
            end else begin
              byte_cnt_next = byte_cnt_reg + 2'd1;
            end
          end else if (byte_cnt_reg != 2'd0) begin
            // Idle cycle inside a partial word.
            if (gap_reg == GAP_LAST) begin
              byte_cnt_next    = '0;
              gap_next         = '0;
              timeout_err_next = 1'b1;
            end else begin
              gap_next = gap_reg + GAP_ONE;
            end
          end
        end

        DRAIN: begin
          // The last word's write pulse is on the outputs during this cycle.
          // The core is released on the following cycle.
          state_next     = RUN;
          cpu_rst_next   = 1'b0;
          load_done_next = 1'b1;
        end

        RUN: begin
          // Bytes are ignored until a reload request arrives.
        end

        default: begin
          state_next = LOAD;
        end
      endcase
    end
  end

  assign imem_we     = imem_we_reg;
  assign imem_addr   = imem_addr_reg;
  assign imem_wdata  = imem_wdata_reg;
  assign cpu_rst     = cpu_rst_reg;
  assign load_done   = load_done_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_uart_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_prog_loader
//
// Directed bench for uart_prog_loader with WORD_COUNT=2, TIMEOUT_CYCLES=10.
// A table of per-cycle {inputs, expected outputs} records covers reset,
// loading, draining, running and reload. Hand-written sequences cover the
// timeout and reset-mid-word cases. Each record drives one cycle. Outputs
// are sampled 1 time unit after the following rising edge.
// ---------------------------------------------------------------------------
module tb_uart_prog_loader;

  localparam int WC = 2;
  localparam int AW = 8;
  localparam int TO = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          reload;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst;
  logic          load_done;
  logic          timeout_err;

  int total = 0;
  int bad   = 0;

  uart_prog_loader #(
    .WORD_COUNT    (WC),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .load_done  (load_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        rl;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic        cr;
    logic        dn;
    logic        er;
  } vec_t;

  vec_t tbl[$];

  // Drive one cycle of inputs, then sample 1 unit after the rising edge.
  task automatic step(input logic v, input logic [7:0] d, input logic rl);
    rx_valid = v;
    rx_data  = d;
    reload   = rl;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic we, input logic [7:0] addr,
                       input logic [31:0] wd, input logic cr, input logic dn,
                       input logic er);
    total++;
    if (imem_we !== we || imem_addr !== addr || imem_wdata !== wd ||
        cpu_rst !== cr || load_done !== dn || timeout_err !== er) begin
      bad++;
      $display("FAIL %s: got we=%b addr=%h wdata=%h cpu_rst=%b done=%b err=%b, want we=%b addr=%h wdata=%h cpu_rst=%b done=%b err=%b",
               name, imem_we, imem_addr, imem_wdata, cpu_rst, load_done, timeout_err,
               we, addr, wd, cr, dn, er);
    end else begin
      $display("ok   %s: we=%b addr=%h wdata=%h cpu_rst=%b done=%b err=%b",
               name, imem_we, imem_addr, imem_wdata, cpu_rst, load_done, timeout_err);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic rl,
                     input logic we, input logic [7:0] addr, input logic [31:0] wd,
                     input logic cr, input logic dn, input logic er);
    vec_t t;
    t.v = v; t.d = d; t.rl = rl; t.we = we; t.addr = addr; t.wd = wd;
    t.cr = cr; t.dn = dn; t.er = er;
    tbl.push_back(t);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reload   = 1'b0;

    // ---------------- reset and idle ----------------
    repeat (3) step(1'b0, 8'h00, 1'b0);
    check("reset", 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (i % 10 == 9) check($sformatf("idle_%0d", i), 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);
    end

    // ---------------- table: load, drain, run, reload ----------------
    //  v     d      rl    we    addr   wdata          cr    dn    er
    add(1'b1, 8'h13, 1'b0, 1'b0, 8'h00, 32'h00000000, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 32'h00000000, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 32'h00000000, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 32'h00100513, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 32'h00100513, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h81, 1'b0, 1'b0, 8'h00, 32'h00100513, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 32'h00100513, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b0, 1'b1, 8'h01, 32'h00208133, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h55, 1'b0, 1'b0, 8'h01, 32'h00208133, 1'b0, 1'b1, 1'b0);
    add(1'b1, 8'h77, 1'b0, 1'b0, 8'h01, 32'h00208133, 1'b0, 1'b1, 1'b0);
    add(1'b1, 8'h99, 1'b0, 1'b0, 8'h01, 32'h00208133, 1'b0, 1'b1, 1'b0);
    add(1'b1, 8'hEE, 1'b1, 1'b0, 8'h01, 32'h00208133, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h11, 1'b0, 1'b0, 8'h01, 32'h00208133, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h22, 1'b0, 1'b0, 8'h01, 32'h00208133, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h33, 1'b0, 1'b0, 8'h01, 32'h00208133, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h44, 1'b0, 1'b1, 8'h00, 32'h44332211, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h44332211, 1'b1, 1'b0, 1'b0);
    // 4th byte arriving with reload must not be written
    add(1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 32'h44332211, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 32'h44332211, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 32'h44332211, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h04, 1'b1, 1'b0, 8'h00, 32'h44332211, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h44332211, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'hA1, 1'b0, 1'b0, 8'h00, 32'h44332211, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'hB2, 1'b0, 1'b0, 8'h00, 32'h44332211, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'hC3, 1'b0, 1'b0, 8'h00, 32'h44332211, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'hD4, 1'b0, 1'b1, 8'h00, 32'hD4C3B2A1, 1'b1, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].rl);
      check($sformatf("vec_%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wd,
            tbl[i].cr, tbl[i].dn, tbl[i].er);
    end

    // ---------------- timeout ----------------
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    repeat (TO - 1) step(1'b0, 8'h00, 1'b0);
    check("timeout_idle9", 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("timeout_idle10", 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'hBB, 1'b0);
    step(1'b1, 8'hCC, 1'b0);
    check("timeout_partial", 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'hDD, 1'b0);
    check("timeout_fresh_word", 1'b1, 8'h00, 32'hDDCCBBAA, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("reload_clears_err", 1'b0, 8'h00, 32'hDDCCBBAA, 1'b1, 1'b0, 1'b0);

    // ---------------- reset mid-word ----------------
    step(1'b1, 8'h10, 1'b0);
    step(1'b1, 8'h20, 1'b0);
    step(1'b1, 8'h30, 1'b0);
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    check("rst_midword", 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    step(1'b1, 8'h04, 1'b0);
    check("rst_new_word", 1'b1, 8'h00, 32'h04030201, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("rst_pulse_end", 1'b0, 8'h00, 32'h04030201, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Boot sequencer between the UART receiver and the instruction memory in the UART-fed CPU top.
- Assembles received bytes into 32-bit little-endian words and writes them to consecutive instruction-memory word addresses.
- Holds the CPU core in reset until WORD_COUNT words are written, then releases the core and flags load completion.
- A reload request restarts the load at any time.

Parameters:
- WORD_COUNT, 16, number of 32-bit words per program image (1..2^ADDR_WIDTH).
- ADDR_WIDTH, 8, instruction-memory word-address width.
- TIMEOUT_CYCLES, 1000, maximum idle cycles allowed between bytes of a partially received word (>=2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_data  input  8  received byte; valid only when rx_valid=1.
- rx_valid  input  1  one-cycle strobe, one byte per strobe.
- reload  input  1  one-cycle request to restart loading from address 0.
- imem_we  output  1  instruction-memory write enable, one-cycle pulse per word.
- imem_addr  output  ADDR_WIDTH  word address for the write.
- imem_wdata  output  32  assembled word.
- cpu_rst  output  1  reset to the CPU core; high while loading.
- load_done  output  1  high while the CPU runs a fully loaded image.
- timeout_err  output  1  sticky: a partial word was discarded on timeout.

Behaviour:
- Reset values: state=LOAD, word index=0, byte count=0, gap counter=0.
- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, load_done=0, timeout_err=0.
- All outputs are registered.
- States: LOAD, DRAIN, RUN.
- LOAD, byte assembly: each rx_valid byte goes into lane byte_cnt; the first byte of a word lands in bits [7:0], the fourth in bits [31:24]. byte_cnt then increments.
- LOAD, word write: when the 4th byte is accepted in cycle N, cycle N+1 drives imem_we=1, imem_addr=word index, imem_wdata=assembled word. byte_cnt returns to 0 and the word index increments.
- LOAD, pipelining: a byte arriving in cycle N+1 is accepted as byte 0 of the next word. There are no dead cycles.
- LOAD to DRAIN: if the accepted 4th byte completes word WORD_COUNT-1, the next state is DRAIN. DRAIN is the write-pulse cycle for the last word.
- DRAIN: always goes to RUN on the next cycle. rx_valid is ignored.
- RUN: cpu_rst=0 and load_done=1, starting the cycle after DRAIN (cycle N+2 relative to the final byte). rx_valid is ignored. imem_we stays 0.
- imem_addr and imem_wdata hold their last written values between pulses.
- Timeout: in LOAD with byte_cnt!=0, the gap counter increments on every cycle without rx_valid and clears on rx_valid.
- Timeout firing: when the gap counter reaches TIMEOUT_CYCLES, the partial word is discarded (byte_cnt=0, gap=0), the word index is unchanged, and timeout_err is set.
- Timeout is inactive when byte_cnt=0.
- Reload: accepted in any state and has priority over rx_valid; a byte arriving in the same cycle is discarded.
- Reload, next cycle: state=LOAD, word index=0, byte_cnt=0, gap=0, cpu_rst=1, load_done=0, timeout_err=0.
- Reload does not retract an imem_we pulse already being driven that cycle. It does suppress the pulse for a 4th byte received in the reload cycle.
- rst mid-load: same effect as reload, plus imem_addr and imem_wdata clear to 0.
- Word-index wrap: impossible, since the index stops at WORD_COUNT.

Test Plan:
- Post-reset idle: assert rst for 3 cycles, no bytes -> cpu_rst=1, load_done=0, imem_we=0 held for 50 cycles.
- Single word, WORD_COUNT=2: bytes 0x13,0x05,0x10,0x00 -> one imem_we pulse the cycle after the 4th byte, addr=0, wdata=0x00100513; cpu_rst still 1.
- Full load, WORD_COUNT=2, back-to-back strobes: 8 bytes ending 0x33,0x81,0x20,0x00 -> second pulse addr=1, wdata=0x00208133; cpu_rst=0 and load_done=1 exactly 2 cycles after the last byte; further bytes produce no writes.
- Timeout, TIMEOUT_CYCLES=10: send 2 bytes, idle 10 cycles -> timeout_err=1, no write. Then send 4 fresh bytes 0xAA,0xBB,0xCC,0xDD -> write addr=0, wdata=0xDDCCBBAA.
- Reload from RUN: after a full load, pulse reload together with an rx_valid byte -> next cycle cpu_rst=1, load_done=0, timeout_err=0, byte discarded. A fresh image rewrites from addr=0.
- Reset mid-word: send 3 bytes, assert rst -> all outputs return to reset values. A following 4-byte sequence writes addr=0 with only the new bytes.
